// File: rtl/fifo_defines_pkg.sv
// fifo_defines_pkg: shared widths, burst sequencer states and segment table entry type
package fifo_defines_pkg;
  localparam int INT_BITS     = 16;
  localparam int SEQ_NUM_SEGS = 4;
  localparam int SEQ_LEN_W    = 16;
  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SEEK,
    SEQ_CONF,
    SEQ_RUN,
    SEQ_HOLD,
    SEQ_DONE
  } seq_state_t;
  typedef struct packed {
    logic [1:0]                 sel;
    logic signed [INT_BITS-1:0] amp;
    logic [SEQ_LEN_W-1:0]       len;
  } seq_seg_t;
endpackage

// File: rtl/gen_seq_seg_table.sv
// gen_seq_seg_table: segment register file, synchronous write, combinational read
module gen_seq_seg_table
  import fifo_defines_pkg::*;
#(
  parameter int  NUM_SEGS = SEQ_NUM_SEGS,
  localparam int IDX_W    = $clog2(NUM_SEGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  seq_seg_t         wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output seq_seg_t         rd_data_o
);
  seq_seg_t mem_q [NUM_SEGS];
  seq_seg_t mem_d [NUM_SEGS];
  always_comb begin
    mem_d = mem_q;
    if (wr_i) mem_d[wr_idx_i] = wr_data_i;
  end
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/gen_burst_sequencer.sv
// gen_burst_sequencer: walks the segment table, configuring the generator and counting its FIFO writes
module gen_burst_sequencer
  import fifo_defines_pkg::*;
#(
  parameter int  NUM_SEGS = SEQ_NUM_SEGS,
  parameter int  LEN_W    = SEQ_LEN_W,
  localparam int IDX_W    = $clog2(NUM_SEGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_i,
  input  logic                seg_wr_i,
  input  logic [IDX_W-1:0]    seg_idx_i,
  input  logic [1:0]          seg_sel_i,
  input  logic [INT_BITS-1:0] seg_amp_i,
  input  logic [LEN_W-1:0]    seg_len_i,
  input  logic                gen_wr_en_i,
  input  logic                fifo_afull_i,
  input  logic                fifo_full_i,
  output logic                en_low_o,
  output logic                enh_conf_o,
  output logic [INT_BITS-1:0] amp_o,
  output logic [1:0]          sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [IDX_W-1:0]    seg_o,
  output logic [LEN_W-1:0]    sample_cnt_o,
  output logic                overflow_o
);
  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    seg_q, seg_d, skip_q, skip_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, inc, cur_len;
  logic [INT_BITS-1:0] amp_q, amp_d;
  logic [1:0]          sel_q, sel_d;
  logic                wrap_q, wrap_d, en_low_q, en_low_d, conf_q, conf_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                last, seg_end;
  seq_seg_t            cur, wr_ent;
  assign wr_ent = {seg_sel_i, seg_amp_i, SEQ_LEN_W'(seg_len_i)};
  gen_seq_seg_table #(.NUM_SEGS(NUM_SEGS)) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (seg_wr_i && !busy_q),
    .wr_idx_i (seg_idx_i),
    .wr_data_i(wr_ent),
    .rd_idx_i (seg_q),
    .rd_data_o(cur)
  );
  assign cur_len = LEN_W'(cur.len);
  assign inc     = cnt_q + 1'b1;
  assign last    = seg_q == IDX_W'(NUM_SEGS - 1);
  assign seg_end = gen_wr_en_i && inc == cur_len;
  // skip_q counts consecutive empty entries so an all-empty looping table still terminates
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    amp_d   = amp_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q | (gen_wr_en_i & fifo_full_i);
    case (state_q)
      SEQ_IDLE: if (start_i && !stop_i) begin
        state_d = SEQ_SEEK;
        seg_d   = '0;
        skip_d  = '0;
        cnt_d   = '0;
        wrap_d  = 1'b0;
        ovf_d   = gen_wr_en_i & fifo_full_i;
      end
      SEQ_SEEK: begin
        if (wrap_q && !loop_i) state_d = SEQ_DONE;
        else if (cur.len == '0) begin
          seg_d  = seg_q + 1'b1;
          skip_d = skip_q + 1'b1;
          if (skip_q == IDX_W'(NUM_SEGS - 1) || (last && !loop_i)) state_d = SEQ_DONE;
        end else begin
          state_d = SEQ_CONF;
          skip_d  = '0;
          wrap_d  = 1'b0;
          amp_d   = cur.amp;
          sel_d   = cur.sel;
        end
      end
      SEQ_CONF: state_d = SEQ_RUN;
      SEQ_RUN, SEQ_HOLD: begin
        if (gen_wr_en_i) cnt_d = inc;
        if (seg_end) begin
          cnt_d   = '0;
          seg_d   = seg_q + 1'b1;
          wrap_d  = last;
          state_d = SEQ_SEEK;
        end else state_d = fifo_afull_i ? SEQ_HOLD : SEQ_RUN;
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (stop_i) state_d = SEQ_IDLE;
    en_low_d = state_d != SEQ_RUN;
    conf_d   = state_d == SEQ_CONF;
    busy_d   = state_d != SEQ_IDLE;
    done_d   = state_d == SEQ_DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= SEQ_IDLE;
      seg_q    <= '0;
      skip_q   <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      amp_q    <= '0;
      sel_q    <= '0;
      ovf_q    <= 1'b0;
      en_low_q <= 1'b1;
      conf_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      skip_q   <= skip_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      amp_q    <= amp_d;
      sel_q    <= sel_d;
      ovf_q    <= ovf_d;
      en_low_q <= en_low_d;
      conf_q   <= conf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign en_low_o     = en_low_q;
  assign enh_conf_o   = conf_q;
  assign amp_o        = amp_q;
  assign sel_o        = sel_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign seg_o        = seg_q;
  assign sample_cnt_o = cnt_q;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_gen_burst_sequencer.sv
// tb_gen_burst_sequencer: randomized and directed checks against a segment-list reference model
module tb_gen_burst_sequencer;
  import fifo_defines_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic                rst, start_i, stop_i, loop_i, seg_wr_i;
  logic [1:0]          seg_idx_i, seg_sel_i;
  logic [INT_BITS-1:0] seg_amp_i;
  logic [15:0]         seg_len_i;
  logic                gen_wr_en_i, fifo_afull_i, fifo_full_i;
  logic                en_low_o, enh_conf_o, busy_o, done_o, overflow_o;
  logic [INT_BITS-1:0] amp_o;
  logic [1:0]          sel_o, seg_o;
  logic [15:0]         sample_cnt_o;
  gen_burst_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
    .seg_wr_i(seg_wr_i), .seg_idx_i(seg_idx_i), .seg_sel_i(seg_sel_i),
    .seg_amp_i(seg_amp_i), .seg_len_i(seg_len_i), .gen_wr_en_i(gen_wr_en_i),
    .fifo_afull_i(fifo_afull_i), .fifo_full_i(fifo_full_i), .en_low_o(en_low_o),
    .enh_conf_o(enh_conf_o), .amp_o(amp_o), .sel_o(sel_o), .busy_o(busy_o),
    .done_o(done_o), .seg_o(seg_o), .sample_cnt_o(sample_cnt_o), .overflow_o(overflow_o)
  );
  localparam logic [40:0] RST_VEC = {1'b1, 40'b0};
  int checks = 0, errors = 0;
  int                  t_len [4];
  logic [1:0]          t_sel [4];
  logic [INT_BITS-1:0] t_amp [4];
  longint obs_sig;
  int     obs_done, obs_writes, obs_cnt_bad, obs_cfg_bad, obs_first_conf, obs_first_run;
  bit     obs_timeout;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    {start_i, stop_i, loop_i, seg_wr_i, gen_wr_en_i, fifo_afull_i, fifo_full_i} = '0;
    {seg_idx_i, seg_sel_i, seg_amp_i, seg_len_i} = '0;
    tick();
    tick();
    rst = 1'b1;
    foreach (t_len[i]) begin
      t_len[i] = 0;
      t_sel[i] = '0;
      t_amp[i] = '0;
    end
  endtask
  task automatic prog(input int idx, input logic [1:0] sel, input logic [INT_BITS-1:0] amp, input int len);
    seg_wr_i  = 1'b1;
    seg_idx_i = 2'(idx);
    seg_sel_i = sel;
    seg_amp_i = amp;
    seg_len_i = 16'(len);
    tick();
    seg_wr_i = 1'b0;
    t_len[idx] = len;
    t_sel[idx] = sel;
    t_amp[idx] = amp;
  endtask
  // Expected configured-segment order encoded base 5 (digit = index + 1), one pass, no loop
  function automatic longint exp_sig();
    longint s = 0;
    for (int i = 0; i < 4; i++) if (t_len[i] != 0) s = s * 5 + i + 1;
    return s;
  endfunction
  function automatic int exp_writes();
    int s = 0;
    for (int i = 0; i < 4; i++) s += t_len[i];
    return s;
  endfunction
  // Acts as the generator: writes only while enabled and only as many samples as the model allows
  task automatic run(input int max_cyc, input int afull_rate, input int stop_n);
    int remaining = 0, cur_len = 0, n_conf = 0;
    obs_sig = 0;
    {obs_done, obs_writes, obs_cnt_bad, obs_cfg_bad} = '0;
    obs_first_conf = -1;
    obs_first_run  = -1;
    obs_timeout    = 1'b1;
    start_i = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      start_i = 1'b0;
      gen_wr_en_i = 1'b0;
      fifo_afull_i = 1'b0;
      if (!busy_o) begin
        obs_timeout = 1'b0;
        break;
      end
      if (!en_low_o) begin
        if (obs_first_run < 0) obs_first_run = c;
        if (sample_cnt_o !== 16'(cur_len - remaining)) obs_cnt_bad++;
      end
      if (enh_conf_o) begin
        if (obs_first_conf < 0) obs_first_conf = c;
        n_conf++;
        obs_sig = obs_sig * 5 + longint'(seg_o) + 1;
        if (amp_o !== t_amp[seg_o] || sel_o !== t_sel[seg_o]) obs_cfg_bad++;
        cur_len = t_len[seg_o];
        remaining = cur_len;
      end
      if (done_o) obs_done++;
      if (stop_n > 0 && n_conf >= stop_n) begin
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        obs_timeout = 1'b0;
        break;
      end
      if (!en_low_o && remaining > 0 && $urandom_range(0, 2) != 0) begin
        gen_wr_en_i = 1'b1;
        remaining--;
        obs_writes++;
      end
      if (afull_rate > 0) fifo_afull_i = ($urandom_range(0, afull_rate - 1) == 0);
    end
    gen_wr_en_i = 1'b0;
    fifo_afull_i = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({en_low_o, enh_conf_o, amp_o, sel_o, busy_o, done_o, seg_o, sample_cnt_o, overflow_o} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h",
        {en_low_o, enh_conf_o, amp_o, sel_o, busy_o, done_o, seg_o, sample_cnt_o, overflow_o}, RST_VEC);
    end
  endtask
  task automatic test_single();
    do_reset();
    prog(0, 2'd1, 16'd3, 5);
    run(100, 0, 0);
    checks++;
    if (obs_sig !== 1 || obs_timeout) begin
      errors++;
      $display("FAIL single_order: got sig %0d timeout %0d expected sig 1 timeout 0", obs_sig, obs_timeout);
    end
    checks++;
    if (amp_o !== 16'd3 || sel_o !== 2'd1 || obs_cfg_bad != 0) begin
      errors++;
      $display("FAIL single_conf: got amp %0d sel %0d cfg_bad %0d expected 3 1 0", amp_o, sel_o, obs_cfg_bad);
    end
    checks++;
    if (obs_writes != 5 || obs_cnt_bad != 0) begin
      errors++;
      $display("FAIL single_count: got writes %0d cnt_bad %0d expected 5 0", obs_writes, obs_cnt_bad);
    end
    checks++;
    if (obs_first_conf != 2 || obs_first_run != 3) begin
      errors++;
      $display("FAIL single_latency: got conf@%0d run@%0d expected conf@2 run@3", obs_first_conf, obs_first_run);
    end
    checks++;
    if (obs_done != 1 || busy_o !== 1'b0 || en_low_o !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done %0d busy %0d en_low %0d expected 1 0 1", obs_done, busy_o, en_low_o);
    end
  endtask
  task automatic test_skip();
    do_reset();
    prog(0, 2'd2, 16'd7, 4);
    prog(2, 2'd3, 16'hFFFB, 2);
    run(200, 3, 0);
    checks++;
    if (obs_sig !== 8 || obs_timeout) begin
      errors++;
      $display("FAIL skip_order: got sig %0d timeout %0d expected sig 8 timeout 0", obs_sig, obs_timeout);
    end
    checks++;
    if (obs_writes != 6 || obs_cnt_bad != 0 || obs_cfg_bad != 0) begin
      errors++;
      $display("FAIL skip_count: got writes %0d cnt_bad %0d cfg_bad %0d expected 6 0 0", obs_writes, obs_cnt_bad, obs_cfg_bad);
    end
    checks++;
    if (obs_done != 1) begin
      errors++;
      $display("FAIL skip_done: got %0d expected 1", obs_done);
    end
  endtask
  task automatic test_backpressure();
    int dones = 0;
    do_reset();
    prog(0, 2'd1, 16'd9, 6);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    gen_wr_en_i = 1'b1;
    tick();
    fifo_afull_i = 1'b1;
    tick();
    checks++;
    if (en_low_o !== 1'b1 || sample_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL bp_pause: got en_low %0d cnt %0d expected 1 2", en_low_o, sample_cnt_o);
    end
    tick();
    gen_wr_en_i = 1'b0;
    checks++;
    if (en_low_o !== 1'b1 || sample_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL bp_inflight: got en_low %0d cnt %0d expected 1 3", en_low_o, sample_cnt_o);
    end
    tick();
    fifo_afull_i = 1'b0;
    tick();
    checks++;
    if (en_low_o !== 1'b0 || sample_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL bp_resume: got en_low %0d cnt %0d expected 0 3", en_low_o, sample_cnt_o);
    end
    gen_wr_en_i = 1'b1;
    tick();
    tick();
    tick();
    gen_wr_en_i = 1'b0;
    checks++;
    if (en_low_o !== 1'b1 || sample_cnt_o !== 16'd0 || seg_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_end: got en_low %0d cnt %0d seg %0d expected 1 0 1", en_low_o, sample_cnt_o, seg_o);
    end
    for (int c = 0; c < 20 && busy_o; c++) begin
      tick();
      if (done_o) dones++;
    end
    checks++;
    if (dones != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got done %0d busy %0d expected 1 0", dones, busy_o);
    end
  endtask
  task automatic test_loop_stop();
    longint s = 0;
    do_reset();
    prog(0, 2'd1, 16'd1, 2);
    prog(1, 2'd2, 16'd2, 2);
    loop_i = 1'b1;
    run(300, 0, 5);
    loop_i = 1'b0;
    for (int k = 0; k < 5; k++) s = s * 5 + (k % 2) + 1;
    checks++;
    if (obs_sig !== s || obs_timeout) begin
      errors++;
      $display("FAIL loop_order: got sig %0d timeout %0d expected sig %0d timeout 0", obs_sig, obs_timeout, s);
    end
    checks++;
    if (obs_writes != 8 || obs_cnt_bad != 0 || obs_done != 0) begin
      errors++;
      $display("FAIL loop_count: got writes %0d cnt_bad %0d done %0d expected 8 0 0", obs_writes, obs_cnt_bad, obs_done);
    end
    checks++;
    if (busy_o !== 1'b0 || en_low_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: got busy %0d en_low %0d done %0d expected 0 1 0", busy_o, en_low_o, done_o);
    end
  endtask
  task automatic test_all_zero();
    do_reset();
    loop_i = 1'b1;
    run(50, 0, 0);
    loop_i = 1'b0;
    checks++;
    if (obs_sig !== 0 || obs_done != 1 || obs_timeout) begin
      errors++;
      $display("FAIL all_zero: got sig %0d done %0d timeout %0d expected 0 1 0", obs_sig, obs_done, obs_timeout);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    gen_wr_en_i = 1'b1;
    fifo_full_i = 1'b1;
    tick();
    gen_wr_en_i = 1'b0;
    fifo_full_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %0d expected 1", overflow_o);
    end
    tick();
    tick();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0d expected 1", overflow_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %0d expected 0", overflow_o);
    end
    for (int c = 0; c < 20 && busy_o; c++) tick();
  endtask
  task automatic test_busy_write();
    do_reset();
    prog(0, 2'd1, 16'd4, 3);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    seg_wr_i  = 1'b1;
    seg_idx_i = 2'd1;
    seg_sel_i = 2'd2;
    seg_amp_i = 16'd11;
    seg_len_i = 16'd2;
    stop_i    = 1'b1;
    tick();
    seg_wr_i = 1'b0;
    stop_i   = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || amp_o !== 16'd4) begin
      errors++;
      $display("FAIL busy_stop: got busy %0d done %0d amp %0d expected 0 0 4", busy_o, done_o, amp_o);
    end
    run(100, 0, 0);
    checks++;
    if (obs_sig !== 1 || obs_writes != 3 || obs_timeout) begin
      errors++;
      $display("FAIL busy_write_ignored: got sig %0d writes %0d timeout %0d expected 1 3 0", obs_sig, obs_writes, obs_timeout);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    prog(0, 2'd3, 16'd5, 10);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    gen_wr_en_i = 1'b1;
    tick();
    tick();
    gen_wr_en_i = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if ({en_low_o, enh_conf_o, amp_o, sel_o, busy_o, done_o, seg_o, sample_cnt_o, overflow_o} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h",
        {en_low_o, enh_conf_o, amp_o, sel_o, busy_o, done_o, seg_o, sample_cnt_o, overflow_o}, RST_VEC);
    end
    rst = 1'b1;
    t_len[0] = 0;
    run(50, 0, 0);
    checks++;
    if (obs_sig !== 0 || obs_done != 1 || obs_timeout) begin
      errors++;
      $display("FAIL reset_table: got sig %0d done %0d timeout %0d expected 0 1 0", obs_sig, obs_done, obs_timeout);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 4; i++)
        prog(i, 2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 6)));
      run(800, 4, 0);
      checks++;
      if (obs_sig !== exp_sig() || obs_timeout) begin
        errors++;
        $display("FAIL rand_order[%0d]: got sig %0d timeout %0d expected sig %0d timeout 0", it, obs_sig, obs_timeout, exp_sig());
      end
      checks++;
      if (obs_writes != exp_writes() || obs_cnt_bad != 0 || obs_cfg_bad != 0) begin
        errors++;
        $display("FAIL rand_count[%0d]: got writes %0d cnt_bad %0d cfg_bad %0d expected %0d 0 0",
          it, obs_writes, obs_cnt_bad, obs_cfg_bad, exp_writes());
      end
      checks++;
      if (obs_done != 1) begin
        errors++;
        $display("FAIL rand_done[%0d]: got %0d expected 1", it, obs_done);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_skip();
    test_backpressure();
    test_loop_stop();
    test_all_zero();
    test_overflow();
    test_busy_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
